// File: rtl/booth_divider_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and the iteration counter sizing helper.
package booth_divider_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/booth_divider_seq_div_substep.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract |divisor|.
// Purely combinational, no backpressure; the caller registers the outputs.
module div_substep #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor_mag,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign fits     = shifted >= {1'b0, divisor_mag};
  assign diff     = shifted[WIDTH:0] - divisor_mag;
  assign next_rem = fits ? diff : shifted[WIDTH:0];
  assign next_quo = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed divider, one quotient bit per clock; out_valid rises WIDTH+2 edges after accept
// (1 for divide-by-zero). in_ready only in IDLE; results held in DONE until out_ready.
module booth_divider_seq
  import booth_divider_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   divisor_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_quo;
  logic             quo_neg;
  logic             rem_neg;
  logic             ovf_q;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH:0]   divisor_mag;
  logic             divisor_zero;
  logic             last_iter;

  // |MIN_NEG| wraps back to MIN_NEG, which reads correctly as an unsigned magnitude.
  assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = {1'b0, divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor};
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt == CNT_W'(WIDTH - 1));

  div_substep #(.WIDTH(WIDTH)) u_substep (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (divisor_q),
    .next_rem    (next_rem),
    .next_quo    (next_quo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = divisor_zero ? DONE : CALC;
      end
      CALC:    if (last_iter) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // Registered from the state, so out_valid trails DONE entry by one cycle.
      out_valid <= (state == DONE) && !(out_valid && out_ready);
      case (state)
        IDLE: begin
          if (in_valid) begin
            quo_q     <= dividend_mag;
            rem_q     <= '0;
            divisor_q <= divisor_mag;
            cnt       <= '0;
            quo_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg   <= dividend[WIDTH-1];
            ovf_q     <= (dividend == MIN_NEG) && (divisor == {WIDTH{1'b1}});
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q <= next_rem;
          quo_q <= next_quo;
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient    <= quo_neg ? (~quo_q + 1'b1) : quo_q;
          remainder   <= rem_neg ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          div_by_zero <= 1'b0;
          overflow    <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Scoreboard bench for booth_divider_seq at WIDTH=8: directed corners, output stall,
// mid-operation reset and a random operand sweep against a / and % reference model.
module tb_booth_divider_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           e0;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   stall_req = 0;
  int   hold_cnt = 0;
  bit   seen = 1'b0;

  booth_divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia;
    int   ib;
    ia    = int'($signed(a));
    ib    = int'($signed(b));
    e.e0  = 0;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.lat = W + 2;
    if (ib == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else if (ia == -(1 << (W - 1)) && ib == -1) begin
      e.q  = {1'b1, {(W-1){1'b0}}};
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      e.q = W'(ia / ib);
      e.r = W'(ia % ib);
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", int'(in_ready), 1);
      return;
    end
    e        = model(a, b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    e.e0 = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Output monitor: owns out_ready and compares every valid cycle against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", int'(out_valid), 0);
          out_ready = 1'b1;
        end else begin
          out_ready = (hold_cnt >= stall_req);
          if (!seen) begin
            check("latency", cyc - exp_q[0].e0 - 1, exp_q[0].lat);
            seen = 1'b1;
          end
          check("quotient", int'(quotient), int'(exp_q[0].q));
          check("remainder", int'(remainder), int'(exp_q[0].r));
          check("div_by_zero", int'(div_by_zero), int'(exp_q[0].dz));
          check("overflow", int'(overflow), int'(exp_q[0].ov));
          check("in_ready_busy", int'(in_ready), 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen     = 1'b0;
            hold_cnt = 0;
          end else begin
            hold_cnt++;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int dir_a[12] = '{100, -100, 100, -100, -128, -128, 5, 127, -128, 0, -1, 127};
  int dir_b[12] = '{7, 7, -7, -7, -1, 1, 0, -128, -128, 5, 2, 1};

  initial begin
    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    check("reset_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) send(W'(dir_a[i]), W'(dir_b[i]));
    drain();

    // Hold the result for 5 cycles while poking in_valid; nothing new may be accepted.
    stall_req = 5;
    send(W'(100), W'(7));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    in_valid = 1'b0;
    drain();
    stall_req = 0;

    // Abort in the third CALC cycle; the partial result must never appear.
    send(W'(100), W'(7));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    seen     = 1'b0;
    hold_cnt = 0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(W'(7), W'(2));
    drain();

    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2: a = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      stall_req = $urandom_range(0, 2);
      send(a, b);
    end
    drain();
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
